// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared encodings and default widths for the GPR write-back arbiter and the load path.
package wb_pkg;

    localparam int unsigned DATA_W_DFLT = 64;
    localparam int unsigned ADDR_W_DFLT = 5;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } ld_size_e;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LD  = 1'b1
    } wr_src_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Producer handshakes and register-file write port of the write-back arbiter.
interface regfile_wb_arbiter_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 5
) ();

    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;

    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_rd;
    logic [DATA_W-1:0] ld_data;
    logic [1:0]        ld_size;
    logic              ld_sext;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_src;

    // Environment side: producers plus the register file.
    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_valid, ld_rd, ld_data, ld_size, ld_sext,
        input  alu_ready, ld_ready,
        input  wr_en, wr_addr, wr_data, wr_src
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_valid, ld_rd, ld_data, ld_size, ld_sext,
        output alu_ready, ld_ready,
        output wr_en, wr_addr, wr_data, wr_src
    );

endinterface

// File: rtl/regfile_wb_arbiter_load_extend.sv
// Zero/sign extension of right-justified load data to 64 bits.
module load_extend
    import wb_pkg::*;
(
    input  logic [63:0] ld_data_i,
    input  logic [1:0]  ld_size_i,
    input  logic        ld_sext_i,
    output logic [63:0] ext_o
);

    logic fill_b;
    logic fill_h;
    logic fill_w;

    assign fill_b = ld_sext_i & ld_data_i[7];
    assign fill_h = ld_sext_i & ld_data_i[15];
    assign fill_w = ld_sext_i & ld_data_i[31];

    always_comb begin
        ext_o = ld_data_i;
        unique case (ld_size_e'(ld_size_i))
            SZ_B:    ext_o = {{56{fill_b}}, ld_data_i[7:0]};
            SZ_H:    ext_o = {{48{fill_h}}, ld_data_i[15:0]};
            SZ_W:    ext_o = {{32{fill_w}}, ld_data_i[31:0]};
            SZ_D:    ext_o = ld_data_i;
            default: ext_o = ld_data_i;
        endcase
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Schedules the single GPR write port between the ALU and load producers, each
// buffered by a one-entry holding register; loads win unless the ALU has starved.
module regfile_wb_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DFLT,
    parameter int unsigned ADDR_W     = ADDR_W_DFLT,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic               clk,
    input  logic               rst,
    regfile_wb_arbiter_if.slave bus
);

    localparam int unsigned CntW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_MAX);

    // Holding buffers
    logic              alu_full_q, alu_full_d;
    logic [ADDR_W-1:0] alu_rd_q, alu_rd_d;
    logic [DATA_W-1:0] alu_data_q, alu_data_d;

    logic              ld_full_q, ld_full_d;
    logic [ADDR_W-1:0] ld_rd_q, ld_rd_d;
    logic [DATA_W-1:0] ld_data_q, ld_data_d;

    logic [CntW-1:0]   starve_q, starve_d;

    // Registered write port
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    wr_src_e           wr_src_q, wr_src_d;

    logic              grant_alu;
    logic              grant_ld;
    logic              alu_ready;
    logic              ld_ready;
    logic              alu_accept;
    logic              ld_accept;
    logic [63:0]       ld_ext;

    load_extend u_load_extend (
        .ld_data_i (bus.ld_data),
        .ld_size_i (bus.ld_size),
        .ld_sext_i (bus.ld_sext),
        .ext_o     (ld_ext)
    );

    always_comb begin
        grant_ld  = ld_full_q && !(alu_full_q && (starve_q == StarveMax));
        grant_alu = alu_full_q && !grant_ld;
    end

    // A buffer granted this cycle frees its slot at the same edge, so a new
    // entry can be taken without a bubble.
    assign alu_ready  = !rst && (!alu_full_q || grant_alu);
    assign ld_ready   = !rst && (!ld_full_q || grant_ld);
    assign alu_accept = bus.alu_valid && alu_ready;
    assign ld_accept  = bus.ld_valid && ld_ready;

    always_comb begin
        alu_full_d = alu_full_q;
        alu_rd_d   = alu_rd_q;
        alu_data_d = alu_data_q;
        if (grant_alu) begin
            alu_full_d = 1'b0;
        end
        if (alu_accept) begin
            alu_full_d = 1'b1;
            alu_rd_d   = bus.alu_rd;
            alu_data_d = bus.alu_data;
        end
    end

    always_comb begin
        ld_full_d = ld_full_q;
        ld_rd_d   = ld_rd_q;
        ld_data_d = ld_data_q;
        if (grant_ld) begin
            ld_full_d = 1'b0;
        end
        if (ld_accept) begin
            ld_full_d = 1'b1;
            ld_rd_d   = bus.ld_rd;
            ld_data_d = ld_ext;
        end
    end

    always_comb begin
        starve_d = '0;
        if (alu_full_q && !grant_alu) begin
            starve_d = (starve_q == StarveMax) ? starve_q : starve_q + 1'b1;
        end
    end

    always_comb begin
        wr_en_d   = grant_alu || grant_ld;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_src_d  = wr_src_q;
        if (grant_ld) begin
            wr_addr_d = ld_rd_q;
            wr_data_d = ld_data_q;
            wr_src_d  = SRC_LD;
        end else if (grant_alu) begin
            wr_addr_d = alu_rd_q;
            wr_data_d = alu_data_q;
            wr_src_d  = SRC_ALU;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_full_q <= 1'b0;
            alu_rd_q   <= '0;
            alu_data_q <= '0;
            ld_full_q  <= 1'b0;
            ld_rd_q    <= '0;
            ld_data_q  <= '0;
            starve_q   <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_src_q   <= SRC_ALU;
        end else begin
            alu_full_q <= alu_full_d;
            alu_rd_q   <= alu_rd_d;
            alu_data_q <= alu_data_d;
            ld_full_q  <= ld_full_d;
            ld_rd_q    <= ld_rd_d;
            ld_data_q  <= ld_data_d;
            starve_q   <= starve_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_src_q   <= wr_src_d;
        end
    end

    assign bus.alu_ready = alu_ready;
    assign bus.ld_ready  = ld_ready;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.wr_src    = wr_src_q;

    a_one_grant : assert property (@(posedge clk) disable iff (rst) !(grant_alu && grant_ld));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: expected writes are queued in spec order
// and popped by a monitor on every wr_en cycle.
module tb_regfile_wb_arbiter;
    import wb_pkg::*;

    localparam int unsigned StarveMax = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.DATA_W(64), .ADDR_W(5)) bus ();

    regfile_wb_arbiter #(
        .DATA_W     (64),
        .ADDR_W     (5),
        .STARVE_MAX (StarveMax)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [4:0]  addr;
        logic [63:0] data;
        logic        src;
    } wr_t;

    typedef struct packed {
        logic [63:0] d;
        logic [1:0]  sz;
        logic        sx;
        logic [63:0] e;
    } ext_vec_t;

    localparam ext_vec_t ExtVec [7] = '{
        '{64'h0000_0000_0000_80F0, 2'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0},
        '{64'h0000_0000_0000_80F0, 2'd1, 1'b0, 64'h0000_0000_0000_80F0},
        '{64'h0000_0000_0000_80F0, 2'd1, 1'b1, 64'hFFFF_FFFF_FFFF_80F0},
        '{64'h0000_0000_0000_80F0, 2'd0, 1'b0, 64'h0000_0000_0000_00F0},
        '{64'h1234_5678_8000_0001, 2'd2, 1'b1, 64'hFFFF_FFFF_8000_0001},
        '{64'h1234_5678_8000_0001, 2'd2, 1'b0, 64'h0000_0000_8000_0001},
        '{64'h8765_4321_0FED_CBA9, 2'd3, 1'b1, 64'h8765_4321_0FED_CBA9}
    };

    wr_t exp_q [$];
    int  checks = 0;
    int  errors = 0;

    // Reference extension built from shifts rather than bit replication.
    function automatic logic [63:0] ext_model(input logic [63:0] d, input logic [1:0] sz,
                                              input logic sx);
        int          sh;
        logic [63:0] v;
        sh = 64 - (8 << sz);
        v  = d << sh;
        if (sx) return 64'($signed(v) >>> sh);
        return v >> sh;
    endfunction

    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            wr_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%0d data=%h src=%0d, required no write",
                         bus.wr_addr, bus.wr_data, bus.wr_src);
            end else begin
                e = exp_q.pop_front();
                if ({bus.wr_addr, bus.wr_data, bus.wr_src} !== e) begin
                    errors++;
                    $display("FAIL write_order: got addr=%0d data=%h src=%0d, required addr=%0d data=%h src=%0d",
                             bus.wr_addr, bus.wr_data, bus.wr_src, e.addr, e.data, e.src);
                end
            end
        end
    end

    task automatic send_alu(input logic [4:0] rd, input logic [63:0] d, output int stalls);
        int n;
        bit acc;
        n = 0;
        acc = 0;
        stalls = 0;
        bus.alu_rd    = rd;
        bus.alu_data  = d;
        bus.alu_valid = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = bus.alu_ready;
            if (!acc) stalls++;
            @(posedge clk);
            #1;
            n++;
        end
        bus.alu_valid = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL alu_accept_timeout: got no handshake in %0d cycles, required one", n);
        end
    endtask

    task automatic send_ld(input logic [4:0] rd, input logic [63:0] d, input logic [1:0] sz,
                           input logic sx, output int stalls);
        int n;
        bit acc;
        n = 0;
        acc = 0;
        stalls = 0;
        bus.ld_rd    = rd;
        bus.ld_data  = d;
        bus.ld_size  = sz;
        bus.ld_sext  = sx;
        bus.ld_valid = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = bus.ld_ready;
            if (!acc) stalls++;
            @(posedge clk);
            #1;
            n++;
        end
        bus.ld_valid = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL ld_accept_timeout: got no handshake in %0d cycles, required one", n);
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d writes still pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (bus.alu_ready !== 1'b0 || bus.ld_ready !== 1'b0) begin
                errors++;
                $display("FAIL reset_ready: got alu_ready=%b ld_ready=%b, required 0 0",
                         bus.alu_ready, bus.ld_ready);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (bus.wr_en !== 1'b0 || bus.wr_addr !== 5'd0 || bus.wr_data !== 64'd0 ||
                bus.wr_src !== 1'b0 || bus.alu_ready !== 1'b1 || bus.ld_ready !== 1'b1) begin
                errors++;
                $display("FAIL idle_state: got wr_en=%b wr_addr=%0d wr_data=%h wr_src=%b rdy=%b%b, required 0 0 0 0 11",
                         bus.wr_en, bus.wr_addr, bus.wr_data, bus.wr_src,
                         bus.alu_ready, bus.ld_ready);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_alu();
        int st;
        exp_q.push_back('{5'd3, 64'h1234, 1'b0});
        send_alu(5'd3, 64'h1234, st);
        wait_drain("single_alu");
    endtask

    task automatic test_load_ext();
        int st;
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back('{5'(8 + i), ExtVec[i].e, 1'b1});
            send_ld(5'(8 + i), ExtVec[i].d, ExtVec[i].sz, ExtVec[i].sx, st);
        end
        wait_drain("load_ext");
    endtask

    task automatic test_simultaneous();
        int st_a;
        int st_l;
        exp_q.push_back('{5'd2, 64'hB2, 1'b1});
        exp_q.push_back('{5'd1, 64'hA1, 1'b0});
        fork
            send_alu(5'd1, 64'hA1, st_a);
            send_ld(5'd2, 64'hB2, 2'd3, 1'b0, st_l);
        join
        wait_drain("simultaneous");
    endtask

    task automatic test_starvation();
        int st_a;
        int st_total;
        logic [63:0] ld_d [6];
        for (int i = 0; i < 6; i++) ld_d[i] = 64'hF000_0000_0000_0080 + 64'(i);
        // Loads 0..2 win, then the waiting ALU entry is forced through, then loads resume.
        for (int i = 0; i < 3; i++) exp_q.push_back('{5'(21 + i), ext_model(ld_d[i], 2'd0, 1'b1), 1'b1});
        exp_q.push_back('{5'd20, 64'hA5A5, 1'b0});
        for (int i = 3; i < 6; i++) exp_q.push_back('{5'(21 + i), ext_model(ld_d[i], 2'd0, 1'b1), 1'b1});
        st_total = 0;
        fork
            send_alu(5'd20, 64'hA5A5, st_a);
            begin
                for (int i = 0; i < 6; i++) begin
                    int st;
                    send_ld(5'(21 + i), ld_d[i], 2'd0, 1'b1, st);
                    st_total += st;
                end
            end
        join
        checks++;
        if (st_total != 1) begin
            errors++;
            $display("FAIL starve_ld_stall: got %0d ld_ready stall cycles, required 1", st_total);
        end
        wait_drain("starvation");
    endtask

    task automatic test_back_to_back();
        int st;
        int st_total;
        st_total = 0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{5'(i), 64'hC0DE_0000 + 64'(i), 1'b0});
            send_alu(5'(i), 64'hC0DE_0000 + 64'(i), st);
            st_total += st;
        end
        checks++;
        if (st_total != 0) begin
            errors++;
            $display("FAIL b2b_alu_stall: got %0d stall cycles, required 0", st_total);
        end
        wait_drain("back_to_back");
    endtask

    task automatic test_reset_midop();
        bus.alu_rd    = 5'd5;
        bus.alu_data  = 64'hDEAD;
        bus.alu_valid = 1'b1;
        bus.ld_rd     = 5'd6;
        bus.ld_data   = 64'hBEEF;
        bus.ld_size   = 2'd3;
        bus.ld_sext   = 1'b0;
        bus.ld_valid  = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.alu_ready !== 1'b1 || bus.ld_ready !== 1'b1) begin
            errors++;
            $display("FAIL midop_fill_ready: got %b%b, required 11", bus.alu_ready, bus.ld_ready);
        end
        @(posedge clk);
        #1;
        bus.alu_valid = 1'b0;
        bus.ld_valid  = 1'b0;
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (bus.wr_en !== 1'b0 || bus.alu_ready !== 1'b0 || bus.ld_ready !== 1'b0) begin
                errors++;
                $display("FAIL midop_reset: got wr_en=%b rdy=%b%b, required 0 00",
                         bus.wr_en, bus.alu_ready, bus.ld_ready);
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (bus.wr_en !== 1'b0 || bus.wr_addr !== 5'd0) begin
                errors++;
                $display("FAIL midop_stale: got wr_en=%b wr_addr=%0d, required 0 0",
                         bus.wr_en, bus.wr_addr);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bus.alu_valid = 1'b0;
        bus.alu_rd    = '0;
        bus.alu_data  = '0;
        bus.ld_valid  = 1'b0;
        bus.ld_rd     = '0;
        bus.ld_data   = '0;
        bus.ld_size   = '0;
        bus.ld_sext   = 1'b0;
        test_reset();
        test_single_alu();
        test_load_ext();
        test_simultaneous();
        test_starvation();
        test_back_to_back();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog");
    end

endmodule
